// File: rtl/dcache_miss_ctrl.sv
// dcache_miss_ctrl: miss sequencer for the write-back, write-allocate,
// direct-mapped data cache in the MEM stage.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | no miss in flight; stall only while the current access misses
//   WB      | writing the dirty victim line back to memory
//   GAP     | one cycle with enable low between write-back and refill
//   REFILL  | reading the missing line from memory
//   UPDATE  | writing refill data, tag and valid bit into the line
module dcache_miss_ctrl #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 4,
  parameter int OFF_W  = 5,
  parameter int TAG_W  = ADDR_W - IDX_W - OFF_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              hit_i,
  input  logic              victim_dirty_i,
  input  logic [TAG_W-1:0]  victim_tag_i,
  input  logic              mem_ack_i,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              refill_we_o,
  output logic              stall_o,
  output logic [31:0]       miss_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WB     = 3'd1,
    S_GAP    = 3'd2,
    S_REFILL = 3'd3,
    S_UPDATE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   tag_q;
  logic [TAG_W-1:0]   vtag_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        miss_cnt_q;
  logic               miss;

  // offset bits never reach memory: requests are whole-line
  logic unused_off;
  assign unused_off = ^cpu_addr_i[OFF_W-1:0];

  // a miss can only be recognised while idle; later address changes are ignored
  assign miss = (state_q == S_IDLE) && cpu_req_i && !hit_i;

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // latch the missing line and victim tag, and count misses (saturating)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_q      <= '0;
      vtag_q     <= '0;
      idx_q      <= '0;
      miss_cnt_q <= '0;
    end else if (miss) begin
      tag_q  <= cpu_addr_i[ADDR_W-1 -: TAG_W];
      idx_q  <= cpu_addr_i[OFF_W +: IDX_W];
      vtag_q <= victim_tag_i;
      if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  // next-state and outputs; bus fields stay zero whenever enable is low
  always_comb begin
    state_d      = state_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    refill_we_o  = 1'b0;
    stall_o      = 1'b1;
    case (state_q)
      S_IDLE: begin
        stall_o = cpu_req_i && !hit_i;
        if (miss) state_d = victim_dirty_i ? S_WB : S_REFILL;
      end
      S_WB: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {vtag_q, idx_q, {OFF_W{1'b0}}};
        if (mem_ack_i) state_d = S_GAP;
      end
      S_GAP: begin
        state_d = S_REFILL;
      end
      S_REFILL: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {tag_q, idx_q, {OFF_W{1'b0}}};
        if (mem_ack_i) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        refill_we_o = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb_dcache_miss_ctrl: directed table vectors for idle behaviour plus
// hand-written miss sequences against a simple fixed-latency memory model.
module tb_dcache_miss_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cpu_req_i;
  logic [31:0] cpu_addr_i;
  logic        hit_i;
  logic        victim_dirty_i;
  logic [22:0] victim_tag_i;
  logic        mem_ack_i;
  logic        mem_enable_o;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  logic        refill_we_o;
  logic        stall_o;
  logic [31:0] miss_cnt_o;

  int checks   = 0;
  int failures = 0;

  dcache_miss_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_req_i      (cpu_req_i),
    .cpu_addr_i     (cpu_addr_i),
    .hit_i          (hit_i),
    .victim_dirty_i (victim_dirty_i),
    .victim_tag_i   (victim_tag_i),
    .mem_ack_i      (mem_ack_i),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_addr_o     (mem_addr_o),
    .refill_we_o    (refill_we_o),
    .stall_o        (stall_o),
    .miss_cnt_o     (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic        req;
    logic        hit;
    logic        ack;
    logic        exp_stall;
    logic        exp_en;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one miss to completion. Memory acks on the L-th consecutive enable
  // cycle; the tag array reports a hit once the refill write has been seen.
  task automatic do_miss(input string tag, input logic [31:0] addr, input logic dirty,
                         input logic [22:0] vtag, input int lat, input logic noise,
                         input int exp_stall, input int exp_wb, input int exp_rf,
                         input int exp_gap, input logic [31:0] exp_wba,
                         input logic [31:0] exp_rfa);
    int   cnt = 0;
    int   st = 0, wbc = 0, rfc = 0, gapc = 0, wep = 0;
    int   bus_bad = 0, rf_moved = 0;
    logic [31:0] wba = '0, rfa = '0;
    logic filled = 1'b0;
    logic done = 1'b0;
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_addr_i = addr; hit_i = 1'b0;
    victim_dirty_i = dirty; victim_tag_i = vtag; mem_ack_i = 1'b0;
    #1;
    if (stall_o) st++;
    @(posedge clk_i);
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk_i);
      hit_i = filled;
      cpu_addr_i = (noise && mem_enable_o && !mem_write_o) ? (addr ^ 32'h0000_5a00 ^ c) : addr;
      if (mem_enable_o) cnt++; else cnt = 0;
      mem_ack_i = mem_enable_o && (cnt == lat);
      #1;
      if (!mem_enable_o && (mem_write_o || mem_addr_o != 32'd0)) bus_bad++;
      if (mem_enable_o && mem_write_o) begin wbc++; wba = mem_addr_o; end
      if (mem_enable_o && !mem_write_o) begin
        if (rfc > 0 && mem_addr_o != rfa) rf_moved++;
        rfc++; rfa = mem_addr_o;
      end
      if (stall_o && !mem_enable_o && wbc > 0 && rfc == 0 && !refill_we_o) gapc++;
      if (refill_we_o) begin wep++; filled = 1'b1; end
      if (stall_o) st++; else done = 1'b1;
      @(posedge clk_i);
    end
    mem_ack_i = 1'b0;
    check({tag, " completes"}, {31'd0, done}, 32'd1);
    check({tag, " stall cycles"}, st, exp_stall);
    check({tag, " wb cycles"}, wbc, exp_wb);
    check({tag, " refill cycles"}, rfc, exp_rf);
    check({tag, " gap cycles"}, gapc, exp_gap);
    check({tag, " refill_we pulses"}, wep, 32'd1);
    check({tag, " idle bus zero"}, bus_bad, 32'd0);
    check({tag, " refill addr stable"}, rf_moved, 32'd0);
    check({tag, " refill addr"}, rfa, exp_rfa);
    if (exp_wb > 0) check({tag, " wb addr"}, wba, exp_wba);
  endtask

  initial begin
    vecs[0] = '{rst:0, req:1, hit:1, ack:0, exp_stall:0, exp_en:0, exp_cnt:0};
    vecs[1] = '{rst:0, req:0, hit:0, ack:0, exp_stall:0, exp_en:0, exp_cnt:0};
    vecs[2] = '{rst:0, req:0, hit:0, ack:1, exp_stall:0, exp_en:0, exp_cnt:0};
    vecs[3] = '{rst:0, req:1, hit:1, ack:1, exp_stall:0, exp_en:0, exp_cnt:0};
    vecs[4] = '{rst:1, req:1, hit:0, ack:0, exp_stall:1, exp_en:0, exp_cnt:0};
    vecs[5] = '{rst:0, req:0, hit:1, ack:0, exp_stall:0, exp_en:0, exp_cnt:0};

    rst_i = 1'b1; cpu_req_i = 1'b0; cpu_addr_i = '0; hit_i = 1'b0;
    victim_dirty_i = 1'b0; victim_tag_i = '0; mem_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset enable", {31'd0, mem_enable_o}, 32'd0);
    check("reset write", {31'd0, mem_write_o}, 32'd0);
    check("reset addr", mem_addr_o, 32'd0);
    check("reset refill_we", {31'd0, refill_we_o}, 32'd0);
    check("reset stall", {31'd0, stall_o}, 32'd0);
    check("reset miss_cnt", miss_cnt_o, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      rst_i = vecs[i].rst; cpu_req_i = vecs[i].req; hit_i = vecs[i].hit; mem_ack_i = vecs[i].ack;
      cpu_addr_i = 32'h0000_0100 + 32'(i * 32);
      #1;
      check($sformatf("vec%0d stall", i), {31'd0, stall_o}, {31'd0, vecs[i].exp_stall});
      check($sformatf("vec%0d enable", i), {31'd0, mem_enable_o}, {31'd0, vecs[i].exp_en});
      check($sformatf("vec%0d refill_we", i), {31'd0, refill_we_o}, 32'd0);
      check($sformatf("vec%0d miss_cnt", i), miss_cnt_o, vecs[i].exp_cnt);
      @(posedge clk_i);
    end
    @(negedge clk_i);
    rst_i = 1'b0; mem_ack_i = 1'b0; cpu_req_i = 1'b0;
    #1;
    check("after vectors enable", {31'd0, mem_enable_o}, 32'd0);

    do_miss("clean", 32'h0000_0464, 1'b0, 23'h0, 10, 1'b0, 12, 0, 10, 0, 32'h0, 32'h0000_0460);
    check("clean miss_cnt", miss_cnt_o, 32'd1);

    do_miss("dirty", 32'h0000_0864, 1'b1, 23'h000001, 10, 1'b0, 23, 10, 10, 1,
            32'h0000_0260, 32'h0000_0860);
    check("dirty miss_cnt", miss_cnt_o, 32'd2);

    do_miss("noise", 32'h0000_1234, 1'b0, 23'h0, 3, 1'b1, 5, 0, 3, 0, 32'h0, 32'h0000_1220);
    check("noise miss_cnt", miss_cnt_o, 32'd3);

    @(negedge clk_i);
    cpu_req_i = 1'b0; mem_ack_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    check("idle ack enable", {31'd0, mem_enable_o}, 32'd0);
    check("idle ack stall", {31'd0, stall_o}, 32'd0);

    do_miss("b2b first", 32'h0000_4040, 1'b0, 23'h0, 4, 1'b0, 6, 0, 4, 0, 32'h0, 32'h0000_4040);
    do_miss("b2b second", 32'h0000_5088, 1'b1, 23'h00002a, 2, 1'b0, 7, 2, 2, 1,
            32'h0000_5480, 32'h0000_5080);
    check("b2b miss_cnt", miss_cnt_o, 32'd5);

    // reset in the middle of a refill
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_addr_i = 32'h0000_2040; hit_i = 1'b0; victim_dirty_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    check("pre-reset refill enable", {31'd0, mem_enable_o}, 32'd1);
    rst_i = 1'b1; cpu_req_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("mid reset enable", {31'd0, mem_enable_o}, 32'd0);
    check("mid reset refill_we", {31'd0, refill_we_o}, 32'd0);
    check("mid reset miss_cnt", miss_cnt_o, 32'd0);
    check("mid reset stall", {31'd0, stall_o}, 32'd0);
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    check("post reset ack enable", {31'd0, mem_enable_o}, 32'd0);
    check("post reset ack stall", {31'd0, stall_o}, 32'd0);

    // saturation: preload the counter just below its ceiling
    @(negedge clk_i);
    dut.miss_cnt_q = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      do_miss($sformatf("sat%0d", k), 32'h0000_3000 + 32'(k * 32'h100), 1'b0, 23'h0, 2, 1'b0,
              4, 0, 2, 0, 32'h0, 32'h0000_3000 + 32'(k * 32'h100));
      check($sformatf("sat%0d miss_cnt", k), miss_cnt_o, 32'hFFFF_FFFF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
